random_request_arbiter: RTL

- Avalon-MM master that shares the memory-mapped random-number PIO slave (data register at address 0, interrupt mask register at address 2) among NUM_REQ hardware requesters.
- After reset it writes the interrupt mask once to configure the PIO.
- It then serves requests round-robin. For each request it issues a single read of the data register and returns the 32-bit word to the granted requester.
- Enforces a minimum gap between reads so consecutive requesters do not receive the same sample.

---
 rtl/random_request_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/random_request_arbiter.sv
// Round-robin Avalon-MM master sharing one random-number PIO among NUM_REQ requesters.
// Grant arrives 2+READ_LATENCY cycles after arbitration. Requesters are level-held until gnt; no other backpressure.
module random_request_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter int          READ_LATENCY  = 1,
  parameter int          GAP_CYCLES    = 2,
  parameter logic [31:0] IRQ_MASK_INIT = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        rdata,
  output logic               rvalid,
  output logic               busy,
  output logic [1:0]         avm_address,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [31:0]        avm_writedata,
  input  logic [31:0]        avm_readdata
);

  localparam int IW = $clog2(NUM_REQ);

  // Bit 3 of the encoding is chipselect and bit 2 is the write strobe, so the bus
  // is driven straight from state flops; reset gates them off asynchronously.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_WAIT    = 4'b0001,
    ST_DELIVER = 4'b0010,
    ST_GAP     = 4'b0011,
    ST_READ    = 4'b1000,
    ST_INIT    = 4'b1100
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx_v;
  logic          found;
  logic [2:0]    lat_cnt;
  logic [3:0]    gap_cnt;
  int            idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:    state_nxt = ST_IDLE;
      ST_IDLE:    if (found) state_nxt = ST_READ;
      ST_READ:    state_nxt = ST_WAIT;
      ST_WAIT:    if (lat_cnt == 3'd1) state_nxt = ST_DELIVER;
      ST_DELIVER: state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:     if (gap_cnt <= 4'd1) state_nxt = ST_IDLE;
      default:    state_nxt = ST_INIT;
    endcase
  end

  // First requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = idx[IW-1:0];
      if (!found && req[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      sel     <= '0;
      lat_cnt <= '0;
      gap_cnt <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (found) sel <= pick;
        ST_READ: lat_cnt <= 3'(READ_LATENCY);
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) rdata <= avm_readdata;
        end
        ST_DELIVER: begin
          rr_ptr  <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + IW'(1);
          gap_cnt <= 4'(GAP_CYCLES);
        end
        ST_GAP:  gap_cnt <= gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  assign avm_chipselect = state[3] & ~reset;
  assign avm_write_n    = ~(state[2] & ~reset);
  assign avm_address    = {state[2] & ~reset, 1'b0};
  assign avm_writedata  = (state[2] & ~reset) ? IRQ_MASK_INIT : 32'h0;
  assign rvalid         = (state == ST_DELIVER);
  assign busy           = (state != ST_IDLE);

  always_comb begin
    gnt = '0;
    if (rvalid) gnt[sel] = 1'b1;
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_cs_single:  assert property (@(posedge clk) disable iff (reset) avm_chipselect |=> !avm_chipselect);

endmodule
